if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the architectural fetch PC and selects the next PC from sequential increment, a taken branch/jump resolved in ID, or a redirect captured while the PC was stalled. Drives the instruction SRAM read port and feeds `{ce, pc}` to ID over `if_to_id_bus`. ID resolves branches; the delay-slot instruction is already in IF when `br_bus` fires, so no squash is needed.

## Interface
- `RESET_PC`, 32'hBFBF_FFFC: value loaded into the PC on reset; the first fetched address is `RESET_PC + 4` = 32'hBFC0_0000.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stall` input `StallBus`: pipeline stall vector; bit 0 (`Stop`/`NoStop`) freezes the PC.
- `br_bus` input `BR_WD` (33): `{br_e, br_addr[31:0]}` from ID.
- `if_to_id_bus` output `IF_TO_ID_WD` (33): `{ce_reg, pc_reg[31:0]}`.
- `inst_sram_en` output 1: SRAM read enable.
- `inst_sram_wen` output 4: constant 4'b0000.
- `inst_sram_addr` output 32: equals `next_pc`.
- `inst_sram_wdata` output 32: constant 32'b0.

## Operation
- State:
  - `pc_reg[31:0]`
  - `ce_reg`
  - `br_pend`
  - `br_pend_addr[31:0]`
- `next_pc` priority:
  1. `br_e` → `br_addr`
  2. else `br_pend` → `br_pend_addr`
  3. else `pc_reg + 32'd4`, mod 2^32, so 32'hFFFF_FFFC wraps to 0.
- Advance, when `stall[0]==NoStop`:
  - `pc_reg <= next_pc`, `ce_reg <= 1`, `br_pend <= 0`.
- Hold, when `stall[0]==Stop`:
  - `pc_reg` and `ce_reg` keep their values.
  - If `br_e && !br_pend`: `br_pend <= 1`, `br_pend_addr <= br_addr`.
  - If `br_pend` is already set: further `br_e` is ignored and the first capture wins. This covers ID re-presenting the same branch while stalled.
- `inst_sram_en = ~rst & (stall[0]==NoStop)`. The address is presented on the same edge `pc_reg` takes `next_pc`, so the SRAM data for `pc_reg` is available in the following cycle, when ID holds that PC.
- No alignment checking: `br_addr[1:0]` is passed through unchanged.
- States, implicit in `{ce_reg, br_pend}`:
  - `RESET` (0,0): → `RUN` on the first non-stalled cycle.
  - `RUN` (1,0): `br_e` during a stall → `PEND`.
  - `PEND` (1,1): → `RUN` on the first non-stalled cycle, consuming `br_pend_addr` unless a live `br_e` overrides it.
  - A stall arriving in `RESET` with `br_e` set also captures into `br_pend`.

## Timing
- Reset values:
  - `pc_reg` = `RESET_PC`, `ce_reg` = 0, `br_pend` = 0, `br_pend_addr` = 0.
  - Outputs during reset: `if_to_id_bus` = {0, 32'hBFBF_FFFC}, `inst_sram_en` = 0, `inst_sram_addr` = 32'hBFC0_0000.
- Latency:
  - `br_e` in cycle N with no stall → `pc_reg` = `br_addr` in N+1 and `if_to_id_bus.ce` = 1.
  - The delay slot (old `pc_reg`) is the PC ID latches at the edge ending cycle N.
- Redirect under stall:
  - `br_e` in stalled cycle N is captured at the end of N.
  - The first unstalled cycle M > N presents `br_pend_addr` on `inst_sram_addr`; `pc_reg` = `br_pend_addr` in M+1.
- Simultaneous events:
  - Live `br_e` together with `br_pend` in an unstalled cycle: `br_addr` wins and `br_pend` clears.
  - `rst` overrides stall, branch, and pending state in the same cycle.
  - `rst` mid-stall with `br_pend`=1: the pending redirect is discarded.
- Outputs are purely registered or combinational from registered state plus `stall[0]`/`br_bus`; there are no multicycle paths.

## Test plan
- Reset release, no stalls:
  - `inst_sram_addr` is 32'hBFC0_0000 in the first cycle.
  - `if_to_id_bus` sequence: {1,BFC0_0000}, {1,BFC0_0004}, {1,BFC0_0008}.
  - `inst_sram_wen` = 0 throughout.
- Taken branch, no stall:
  - Stimulus: `br_bus` = {1, 32'hBFC0_0100} while `pc_reg` = BFC0_0008.
  - Response: next `pc_reg` = BFC0_0100, then BFC0_0104.
- Branch during 3-cycle stall:
  - Stimulus: `stall[0]`=Stop with `pc_reg`=BFC0_0010; `br_e`=1, `br_addr`=BFC0_0200 in the first stall cycle; `br_e`=0 afterwards.
  - Response: `pc_reg` holds BFC0_0010 and `inst_sram_en` = 0 while stalled. The first free cycle drives `inst_sram_addr` = BFC0_0200; `pc_reg` = BFC0_0200 after it.
- Pending plus second branch:
  - Stimulus: pending BFC0_0200 captured; then a different `br_addr` BFC0_0300 while still stalled; then live `br_e` with BFC0_0400 on release.
  - Response: BFC0_0300 is ignored, and BFC0_0400 wins on release.
- Wrap-around:
  - Stimulus: branch to 32'hFFFF_FFFC.
  - Response: following `pc_reg` = 32'h0000_0000.
- Reset mid-pending:
  - Stimulus: `rst` asserted with `br_pend`=1.
  - Response: after release the fetch restarts at BFC0_0000, not the pending address.

Source files
------------

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the five-stage MIPS pipeline.
//
// Holds the architectural fetch PC and picks the next PC from a live
// branch/jump resolved in ID, a redirect captured while the PC was frozen, or
// the sequential PC + 4. The next PC goes straight to the instruction SRAM
// address so the fetched word arrives one cycle later, when ID holds that PC.
//
// Ports:
//   clk             in   single clock, all state on the rising edge
//   rst             in   synchronous, active-high reset
//   stall           in   pipeline stall vector; bit 0 freezes the PC
//   br_bus          in   {br_e, br_addr[31:0]} from ID
//   if_to_id_bus    out  {ce, pc[31:0]} to ID
//   inst_sram_en    out  SRAM read enable
//   inst_sram_wen   out  SRAM byte write enables (always 0)
//   inst_sram_addr  out  SRAM address (= next PC)
//   inst_sram_wdata out  SRAM write data (always 0)
// ----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
    parameter int          STALL_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic [32:0]        br_bus,
    output logic [32:0]        if_to_id_bus,
    output logic               inst_sram_en,
    output logic [3:0]         inst_sram_wen,
    output logic [31:0]        inst_sram_addr,
    output logic [31:0]        inst_sram_wdata
);

    localparam logic STOP = 1'b1;

    // Encoding is {ce, br_pend}, so both flags fall straight out of the state.
    typedef enum logic [1:0] {
        ST_RESET      = 2'b00,
        ST_RESET_PEND = 2'b01, // stalled out of reset with a redirect captured
        ST_RUN        = 2'b10,
        ST_PEND       = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    logic        br_e;
    logic [31:0] br_addr;
    logic        ce;
    logic        br_pend;
    logic        stop;
    logic [31:0] next_pc;

    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];
    assign ce      = state_q[1];
    assign br_pend = state_q[0];
    assign stop    = (stall[0] == STOP);

    // A live branch outranks a pending one: ID may have resolved a newer
    // control transfer in the very cycle the stall lifts.
    always_comb begin
        if (br_e) begin
            next_pc = br_addr;
        end else if (br_pend) begin
            next_pc = pend_addr_q;
        end else begin
            next_pc = pc_q + 32'd4; // wraps naturally at 2^32
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path
        // through this block leaves a value unassigned and infers a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        pend_addr_d = pend_addr_q;

        if (!stop) begin
            pc_d    = next_pc;
            state_d = ST_RUN;
        end else if (br_e && !br_pend) begin
            // First capture wins; ID re-presents the same branch while stalled.
            pend_addr_d = br_addr;
            state_d     = ce ? ST_PEND : ST_RESET_PEND;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            state_q     <= ST_RESET;
            pc_q        <= RESET_PC;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign if_to_id_bus    = {ce, pc_q};
    assign inst_sram_en    = ~rst & ~stop;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = next_pc;
    assign inst_sram_wdata = 32'b0;

endmodule
